// File: rtl/fp_mant_mul_seq_if.sv
// Handshake/bus bundle for the sequential mantissa multiplier.
// Carries operands, results, and the adder request/response to the shared adder.
// Fully combinational. No state.
//   slave  : multiplier side. It takes start/operands/adder results and drives results/adder operands.
//   master : requester plus shared-adder side. Its directions are the mirror of slave.
interface fp_mant_mul_seq_if #(
    parameter int MANT_W = 24
);
    logic                  start;
    logic [MANT_W-1:0]     mant_a;
    logic [MANT_W-1:0]     mant_b;
    logic                  busy;
    logic                  done;
    logic [2*MANT_W-1:0]   product;
    logic [MANT_W-1:0]     mant_out;
    logic                  norm_shift;
    logic [31:0]           add_a;
    logic [31:0]           add_b;
    logic                  add_cin;
    logic [31:0]           add_sum;
    logic                  add_cout;

    modport slave (
        input  start, mant_a, mant_b, add_sum, add_cout,
        output busy, done, product, mant_out, norm_shift, add_a, add_b, add_cin
    );

    modport master (
        output start, mant_a, mant_b, add_sum, add_cout,
        input  busy, done, product, mant_out, norm_shift, add_a, add_b, add_cin
    );
endinterface

// File: rtl/fp_mant_mul_seq.sv
// Shift-and-add unsigned mantissa multiplier that borrows an external 32-bit adder.
// Latency: done pulses MANT_W+2 cycles after start is sampled, or MANT_W+3 when ROUND_EN is defined.
// Backpressure: none. A start seen while busy is dropped, so only one operation is in flight.
// Ports: clk, rst (sync, active-high), bus (fp_mant_mul_seq_if.slave):
//   start/mant_a/mant_b in; busy/done/product/mant_out/norm_shift out;
//   add_a/add_b/add_cin out to the shared adder, add_sum/add_cout back in the same cycle.
// Optional feature: define ROUND_EN to add a round-to-nearest-even ROUND state.
//   When it is undefined the mantissa is truncated.
module fp_mant_mul_seq #(
    parameter int MANT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    fp_mant_mul_seq_if.slave bus
);
    localparam int CNT_W = $clog2(MANT_W + 1);

`ifdef ROUND_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADD   = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_NORM = 3'd2,
        S_DONE = 3'd4
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [MANT_W-1:0]     acc_q, acc_d;
    logic [MANT_W-1:0]     mplier_q, mplier_d;
    logic [MANT_W-1:0]     mcand_q, mcand_d;
    logic [2*MANT_W-1:0]   product_q, product_d;
    logic [MANT_W-1:0]     mant_out_q, mant_out_d;
    logic                  norm_q, norm_d;

    logic [MANT_W:0]       sum_w;
    logic                  last_add;

    // Partial sum plus the adder carry. The carry becomes the new accumulator MSB after the shift.
    assign sum_w    = bus.add_sum[MANT_W:0];
    assign last_add = (cnt_q == CNT_W'(MANT_W - 1));

`ifdef ROUND_EN
    // Bits below the kept mantissa, left-aligned. The MSB is the guard bit and the rest feed sticky.
    logic [MANT_W-1:0] rnd_low;
    logic              rnd_inc;
    assign rnd_low = norm_q ? product_q[MANT_W-1:0] : {product_q[MANT_W-2:0], 1'b0};
    assign rnd_inc = rnd_low[MANT_W-1] & ((|rnd_low[MANT_W-2:0]) | mant_out_q[0]);
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mplier_q   <= '0;
            mcand_q    <= '0;
            product_q  <= '0;
            mant_out_q <= '0;
            norm_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mplier_q   <= mplier_d;
            mcand_q    <= mcand_d;
            product_q  <= product_d;
            mant_out_q <= mant_out_d;
            norm_q     <= norm_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_ADD;
            S_ADD:   if (last_add) state_d = S_NORM;
`ifdef ROUND_EN
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
`else
            S_NORM:  state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath next values
    always_comb begin
        bus.add_a   = 32'd0;
        bus.add_b   = 32'd0;
        bus.add_cin = 1'b0;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        mcand_d     = mcand_q;
        product_d   = product_q;
        mant_out_d  = mant_out_q;
        norm_d      = norm_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d  = bus.mant_a;
                    mplier_d = bus.mant_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_ADD: begin
                bus.add_a = 32'(acc_q);
                bus.add_b = mplier_q[0] ? 32'(mcand_q) : 32'd0;
                // Shift {sum, mplier} right by one. The consumed multiplier bit falls off the bottom.
                acc_d     = sum_w[MANT_W:1];
                mplier_d  = {sum_w[0], mplier_q[MANT_W-1:1]};
                cnt_d     = cnt_q + CNT_W'(1);
                if (last_add) product_d = {sum_w, mplier_q[MANT_W-1:1]};
            end
            S_NORM: begin
                if (product_q[2*MANT_W-1]) begin
                    norm_d     = 1'b1;
                    mant_out_d = product_q[2*MANT_W-1:MANT_W];
                end else begin
                    norm_d     = 1'b0;
                    mant_out_d = product_q[2*MANT_W-2:MANT_W-1];
                end
            end
`ifdef ROUND_EN
            S_ROUND: begin
                bus.add_a   = 32'(mant_out_q);
                bus.add_cin = rnd_inc;
                // Rounding all-ones overflows to 1.000..0. Renormalise and flag the exponent bump.
                if (bus.add_sum[MANT_W]) begin
                    mant_out_d = {1'b1, {(MANT_W-1){1'b0}}};
                    norm_d     = 1'b1;
                end else begin
                    mant_out_d = bus.add_sum[MANT_W-1:0];
                end
            end
`endif
            default: ;
        endcase

        bus.busy       = (state_q != S_IDLE);
        bus.done       = (state_q == S_DONE);
        bus.product    = product_q;
        bus.mant_out   = mant_out_q;
        bus.norm_shift = norm_q;
    end
endmodule
